// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - client and sdram_controller signals of the port arbiter
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  logic [NUM_PORTS-1:0]    ireq;
  logic [NUM_PORTS-1:0]    iwe;
  logic [22*NUM_PORTS-1:0] iaddr;
  logic [16*NUM_PORTS-1:0] iwdata;
  logic [NUM_PORTS-1:0]    oack;
  logic [NUM_PORTS-1:0]    oerror;
  logic [15:0]             ordata;

  logic                    owrite_req;
  logic [21:0]             owrite_address;
  logic [15:0]             owrite_data;
  logic                    iwrite_ack;
  logic                    oread_req;
  logic [21:0]             oread_address;
  logic [15:0]             iread_data;
  logic                    iread_ack;

  modport slave (
    input  ireq, iwe, iaddr, iwdata, iwrite_ack, iread_data, iread_ack,
    output oack, oerror, ordata, owrite_req, owrite_address, owrite_data,
           oread_req, oread_address
  );

  modport master (
    output ireq, iwe, iaddr, iwdata, iwrite_ack, iread_data, iread_ack,
    input  oack, oerror, ordata, owrite_req, owrite_address, owrite_data,
           oread_req, oread_address
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin arbiter of client ports onto one sdram_controller
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 iclk,
  input  logic                 ireset,
  sdram_port_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     win_q, win_d;
  logic                 we_q, we_d;
  logic [21:0]          addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 wreq_q, wreq_d;
  logic                 rreq_q, rreq_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [15:0]          rdata_q, rdata_d;

  logic [IDX_W-1:0]     grant;
  logic                 found;
  logic [IDX_W-1:0]     cand;
  logic                 req_on;
  logic                 got_ack;

  // Scan starts one past the last winner so every requester is reached within NUM_PORTS grants.
  always_comb begin
    grant = last_q;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NUM_PORTS);
      if (!found && bus.ireq[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  assign req_on  = wreq_q | rreq_q;
  assign got_ack = we_q ? (wreq_q & bus.iwrite_ack) : (rreq_q & bus.iread_ack);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    wreq_d  = 1'b0;
    rreq_d  = 1'b0;
    ack_d   = '0;
    err_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d   = grant;
          last_d  = grant;
          we_d    = bus.iwe[grant];
          addr_d  = bus.iaddr[int'(grant)*22 +: 22];
          wdata_d = bus.iwdata[int'(grant)*16 +: 16];
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Acks only count once the request is visible to the controller.
        if (got_ack) begin
          ack_d[win_q] = 1'b1;
          if (!we_q) rdata_d = bus.iread_data;
          state_d = S_RELEASE;
        end else if (req_on && (cnt_q + 16'd1 == 16'(TIMEOUT_CYCLES))) begin
          ack_d[win_q] = 1'b1;
          err_d[win_q] = 1'b1;
          state_d = S_RELEASE;
        end else begin
          wreq_d = we_q;
          rreq_d = ~we_q;
          if (req_on) cnt_d = cnt_q + 16'd1;
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.owrite_req     = wreq_q;
  assign bus.oread_req      = rreq_q;
  assign bus.owrite_address = addr_q;
  assign bus.oread_address  = addr_q;
  assign bus.owrite_data    = wdata_q;
  assign bus.oack           = ack_q;
  assign bus.oerror         = err_q;
  assign bus.ordata         = rdata_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int TO = 8;

  logic iclk;
  logic ireset;
  int   n_checks;
  int   n_fail;

  sdram_port_arbiter_if #(.NUM_PORTS(NP)) ifc ();

  sdram_port_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .iclk   (iclk),
    .ireset (ireset),
    .bus    (ifc.slave)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One client transaction; ack_after=0 means the controller never answers.
  task automatic do_txn(input string tag, input int port, input bit we, input logic [21:0] addr,
                        input logic [15:0] wd, input int ack_after, input logic [15:0] rd,
                        input bit spurious, input bit exp_err, input logic [15:0] exp_rdata);
    int hi;
    bit other, done;
    logic [NP-1:0] ackv, errv;
    hi = 0; other = 0; done = 0; ackv = '0; errv = '0;
    ifc.iwe[port] = we;
    ifc.iaddr[port*22 +: 22] = addr;
    ifc.iwdata[port*16 +: 16] = wd;
    ifc.ireq[port] = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge iclk);
      ifc.iwrite_ack = 1'b0;
      ifc.iread_ack  = 1'b0;
      if (we ? ifc.oread_req : ifc.owrite_req) other = 1;
      if (ifc.oack != '0) begin
        ackv = ifc.oack;
        errv = ifc.oerror;
        done = 1;
        ifc.ireq[port] = 1'b0;
      end else if (we ? ifc.owrite_req : ifc.oread_req) begin
        hi++;
        if (hi == 1) begin
          check({tag, "_addr"}, we ? ifc.owrite_address : ifc.oread_address, addr);
          if (we) check({tag, "_wdata"}, ifc.owrite_data, wd);
          if (spurious) begin
            if (we) ifc.iread_ack = 1'b1;
            else ifc.iwrite_ack = 1'b1;
          end
        end
        if (hi == ack_after) begin
          if (we) ifc.iwrite_ack = 1'b1;
          else begin
            ifc.iread_ack  = 1'b1;
            ifc.iread_data = rd;
          end
        end
      end
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_oack"}, ackv, NP'(1) << port);
    check({tag, "_oerror"}, errv, exp_err ? (NP'(1) << port) : '0);
    check({tag, "_req_cycles"}, hi, exp_err ? TO : ack_after);
    check({tag, "_wrong_req"}, other, 0);
    check({tag, "_ordata"}, ifc.ordata, exp_rdata);
    @(negedge iclk);
    check({tag, "_oack_pulse"}, ifc.oack, 0);
    check({tag, "_release_gap"}, {ifc.owrite_req, ifc.oread_req}, 2'b00);
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    n_checks = 0;
    n_fail   = 0;
    ifc.ireq = '0; ifc.iwe = '0; ifc.iaddr = '0; ifc.iwdata = '0;
    ifc.iwrite_ack = 1'b0; ifc.iread_ack = 1'b0; ifc.iread_data = '0;
    ireset = 1'b0;
    repeat (3) @(negedge iclk);
    check("rst_wreq", ifc.owrite_req, 0);
    check("rst_rreq", ifc.oread_req, 0);
    check("rst_oack", ifc.oack, 0);
    check("rst_oerror", ifc.oerror, 0);
    check("rst_ordata", ifc.ordata, 0);
    check("rst_waddr", ifc.owrite_address, 0);
    check("rst_raddr", ifc.oread_address, 0);
    check("rst_wdata", ifc.owrite_data, 0);
    ireset = 1'b1;
    @(negedge iclk);

    do_txn("wr_p0", 0, 1'b1, 22'h000010, 16'hA5A5, 3, 16'h0000, 1'b0, 1'b0, 16'h0000);
    do_txn("rd_p2", 2, 1'b0, 22'h3FFFFF, 16'h0000, 1, 16'h1234, 1'b0, 1'b0, 16'h1234);
    do_txn("wrong_ack", 0, 1'b1, 22'h000123, 16'h5A5A, 3, 16'h0000, 1'b1, 1'b0, 16'h1234);
    do_txn("timeout_p1", 1, 1'b1, 22'h000200, 16'hBEEF, 0, 16'h0000, 1'b0, 1'b1, 16'h1234);
    do_txn("after_to_p2", 2, 1'b0, 22'h000300, 16'h0000, 2, 16'h7777, 1'b0, 1'b0, 16'h7777);

    // Reset pulsed while port 3 read is outstanding.
    ifc.iwe = '0;
    for (int p = 0; p < NP; p++) ifc.iaddr[p*22 +: 22] = 22'h000100 + 22'(p);
    ifc.ireq[3] = 1'b1;
    begin
      bit seen;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge iclk);
        if (ifc.oread_req) seen = 1;
      end
      check("p3_issue", seen, 1);
    end
    ireset = 1'b0;
    #1;
    check("rst_mid_rreq", ifc.oread_req, 0);
    @(negedge iclk);
    check("rst_mid_oack", ifc.oack, 0);
    ifc.ireq = '1;
    ireset = 1'b1;

    for (int k = 0; k < 6; k++) begin
      bit acked, done, both;
      int gport;
      logic [NP-1:0] ackv;
      acked = 0; done = 0; both = 0; gport = -1; ackv = '0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge iclk);
        ifc.iread_ack = 1'b0;
        if (ifc.owrite_req && ifc.oread_req) both = 1;
        if (ifc.oack != '0) begin
          ackv = ifc.oack;
          done = 1;
        end else if (ifc.oread_req && !acked) begin
          gport = int'(ifc.oread_address) - 'h100;
          ifc.iread_ack  = 1'b1;
          ifc.iread_data = 16'hC000 + 16'(k);
          acked = 1;
        end
      end
      check($sformatf("rr%0d_port", k), gport, order[k]);
      check($sformatf("rr%0d_oack", k), ackv, NP'(1) << order[k]);
      check($sformatf("rr%0d_one_req", k), both, 0);
      check($sformatf("rr%0d_ordata", k), ifc.ordata, 16'hC000 + 16'(k));
      if (k == 5) ifc.ireq = '0;
      @(negedge iclk);
      check($sformatf("rr%0d_gap", k), {ifc.owrite_req, ifc.oread_req}, 2'b00);
    end

    repeat (4) @(negedge iclk);
    check("idle_end", {ifc.owrite_req, ifc.oread_req}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
# sdram_port_arbiter

Multi-client front end for `sdram_controller`: arbitrates up to NUM_PORTS requesters onto the controller's single write port (`owrite_req`/`owrite_address`/`owrite_data`/`iwrite_ack`) and read port (`oread_req`/`oread_address`/`iread_data`/`iread_ack`). Round-robin, one transaction in flight, with a per-transaction ack timeout. Sits between client logic (CPU, frame reader, DMA) and `sdram_controller`, in the same clock domain.

## Interface
- NUM_PORTS, 4, number of client ports (2..8)
- TIMEOUT_CYCLES, 1023, max cycles to wait for controller ack before abort (1..65535)
- iclk  in  1  system clock, rising edge
- ireset  in  1  asynchronous, active-low reset (0 = reset)
- ireq  in  NUM_PORTS  per-client request level; held until matching oack bit
- iwe  in  NUM_PORTS  per-client direction, 1 = write, 0 = read; stable while ireq high
- iaddr  in  22*NUM_PORTS  client i address in bits [22i+21:22i]
- iwdata  in  16*NUM_PORTS  client i write data in bits [16i+15:16i]
- oack  out  NUM_PORTS  one-cycle completion pulse to the served client
- oerror  out  NUM_PORTS  one-cycle pulse, coincident with oack, on timeout abort
- ordata  out  16  read data, valid in the oack cycle of a read, held until next read completes
- owrite_req  out  1  write request to sdram_controller
- owrite_address  out  22  write address
- owrite_data  out  16  write data
- iwrite_ack  in  1  write done from controller
- oread_req  out  1  read request to sdram_controller
- oread_address  out  22  read address
- iread_data  in  16  read data from controller, valid with iread_ack
- iread_ack  in  1  read done from controller

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE: if any ireq bit set, select winner = first set bit scanning from (last+1) mod NUM_PORTS upward with wrap; register winner index, iwe, iaddr, iwdata slice; set last = winner; clear timeout counter; go ISSUE. No request: stay.
- ISSUE: assert owrite_req (we=1) or oread_req (we=0), never both; address/data outputs driven from registered copy, stable for whole state. Matching ack (iwrite_ack for write, iread_ack for read) sampled high: deassert req next cycle, pulse oack[winner]; for reads capture iread_data into ordata; go RELEASE. Non-matching ack ignored.
- Timeout: counter increments each ISSUE cycle; on reaching TIMEOUT_CYCLES without ack: deassert req, pulse oack[winner] and oerror[winner], ordata unchanged, go RELEASE.
- RELEASE: one cycle, all requests deasserted; winner's ireq ignored this cycle (client drops ireq after oack). Go IDLE.
- Fairness: a continuously requesting port waits at most NUM_PORTS-1 transactions.
- Address/data width: pass-through, no arithmetic; counter 16 bits, saturates never (bounded by TIMEOUT_CYCLES).

## Timing
- Reset (ireset=0), asynchronous: state IDLE, last = NUM_PORTS-1 (port 0 has first priority), oack=0, oerror=0, ordata=0, owrite_req=0, oread_req=0, owrite_address=0, owrite_data=0, oread_address=0, counter=0. Reset mid-ISSUE drops req immediately; no oack for the aborted transaction.
- Latency: ireq sampled at edge N -> owrite_req/oread_req high after edge N+1. Ack sampled at edge M -> req low and oack high after edge M, oack low after edge M+1. Next grant earliest: IDLE sampling at edge M+2, req after M+3.
- Ack arriving in the same cycle req first rises is accepted.
- Simultaneous requests: only one granted; others wait, their ireq must stay high.
- ireq dropped by a non-winner before grant: no effect. ireq dropped by winner mid-ISSUE: ignored, transaction completes.

## Test plan
- Reset then port 0 write addr 22'h000010 data 16'hA5A5, controller acks 3 cycles after owrite_req -> owrite_req high 3 cycles, owrite_address=22'h000010, owrite_data=16'hA5A5, oack=4'b0001 one cycle, oread_req never high.
- Port 2 read addr 22'h3FFFFF, controller returns iread_data=16'h1234 with iread_ack -> oread_address=22'h3FFFFF, oack=4'b0100, ordata=16'h1234 held afterwards.
- All four ports request continuously, controller acks each after 1 cycle -> grant order 0,1,2,3,0,1 with exactly one req active at a time and RELEASE gap between each.
- TIMEOUT_CYCLES=8, port 1 write, controller never acks -> req high exactly 8 cycles then low, oack=oerror=4'b0010 same cycle, ordata unchanged, next port then served.
- Port 3 read in ISSUE, ireset pulsed low mid-transaction -> oread_req=0 immediately, no oack, after release port 0 wins over port 3 when both request.
- Write in progress, controller pulses iread_ack (wrong port) -> ignored, owrite_req stays high until iwrite_ack.
